// File: rtl/mmul_arb_pkg.sv
// Shared types and helpers for the mmul engine arbiter.
// Optional watchdog: define MMUL_ARB_TIMEOUT_EN.
package mmul_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_RESP
    } state_t;

    // Extra RUN cycles tolerated beyond the nominal M*N*L before giving up.
    localparam int TIMEOUT_SLACK = 8;

    // Upper bound on requester count handled by the search helper.
    localparam int MAX_REQ = 32;

    // First set bit at or after ptr, wrapping within n bits; -1 if none set.
    function automatic int rr_first(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
        int res;
        int idx;
        res = -1;
        // Walk downwards so the lowest distance from ptr wins last.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (req[idx[4:0]]) res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mmul_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot grant, index and any-flag.
module rr_pick
    import mmul_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    int                 w_sel;

    // Search from the pointer and encode the winner both ways.
    always_comb begin
        w_req_ext             = '0;
        w_req_ext[NREQ-1:0]   = i_req;
        w_sel                 = rr_first(w_req_ext, NREQ, int'(i_ptr));
        o_any                 = (w_sel >= 0);
        o_idx                 = o_any ? IW'(w_sel) : '0;
        o_grant               = o_any ? (NREQ'(1) << w_sel) : '0;
    end

endmodule

// File: rtl/mmul_arbiter.sv
// Round-robin arbiter sharing one mmul engine between NREQ requesters.
// Optional watchdog on the RUN phase: define MMUL_ARB_TIMEOUT_EN.
module mmul_arbiter
    import mmul_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int M     = 2,
    parameter  int N     = 2,
    parameter  int L     = 2,
    parameter  int WIDTH = 8,
    localparam int IW    = $clog2(NREQ),
    localparam int AW    = M * N * WIDTH,
    localparam int BW    = N * L * WIDTH,
    localparam int RW    = M * L * WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ*AW-1:0] i_req_mat_a,
    input  logic [NREQ*BW-1:0] i_req_mat_b,
    output logic [NREQ-1:0]  o_req_ack,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [IW-1:0]    o_rsp_id,
    output logic [RW-1:0]    o_rsp_mat,
    output logic             o_rsp_err,
    output logic             o_eng_reset,
    output logic             o_eng_enable,
    output logic [AW-1:0]    o_eng_mat_a,
    output logic [BW-1:0]    o_eng_mat_b,
    input  logic [RW-1:0]    i_eng_mat_axb,
    input  logic             i_eng_done,
    input  logic             i_eng_invalid
);

    state_t            r_state;
    logic [IW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_ack;
    logic              r_rsp_valid;
    logic [IW-1:0]     r_rsp_id;
    logic [RW-1:0]     r_rsp_mat;
    logic              r_rsp_err;
    logic              r_eng_reset;
    logic              r_eng_enable;
    logic [AW-1:0]     r_eng_mat_a;
    logic [BW-1:0]     r_eng_mat_b;
`ifdef MMUL_ARB_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(M * N * L + TIMEOUT_SLACK - 1);
    logic [15:0]       r_wdog;
`endif

    logic [NREQ-1:0]   w_grant;
    logic [IW-1:0]     w_idx;
    logic              w_any;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Job sequencer: grant, engine reset, run, drain, respond; all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_ack        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_mat    <= '0;
            r_rsp_err    <= 1'b0;
            r_eng_reset  <= 1'b1;
            r_eng_enable <= 1'b0;
            r_eng_mat_a  <= '0;
            r_eng_mat_b  <= '0;
`ifdef MMUL_ARB_TIMEOUT_EN
            r_wdog       <= '0;
`endif
        end else begin
            r_ack       <= '0;
            r_eng_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_ack       <= w_grant;
                        r_eng_mat_a <= i_req_mat_a[int'(w_idx)*AW +: AW];
                        r_eng_mat_b <= i_req_mat_b[int'(w_idx)*BW +: BW];
                        r_rsp_id    <= w_idx;
                        r_ptr       <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
                        r_eng_reset <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_eng_enable <= 1'b1;
                    r_state      <= ST_RUN;
`ifdef MMUL_ARB_TIMEOUT_EN
                    r_wdog       <= '0;
`endif
                end
                ST_RUN: begin
                    if (i_eng_invalid) begin
                        r_eng_enable <= 1'b0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_mat    <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (i_eng_done) begin
                        r_eng_enable <= 1'b0;
                        r_state      <= ST_DRAIN;
                    end
`ifdef MMUL_ARB_TIMEOUT_EN
                    else if (r_wdog == WDOG_LAST) begin
                        // Engine hung: kick it back to a known state and report.
                        r_eng_enable <= 1'b0;
                        r_eng_reset  <= 1'b1;
                        r_rsp_err    <= 1'b1;
                        r_rsp_mat    <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
`endif
                end
                ST_DRAIN: begin
                    // Engine publishes its result the cycle after done.
                    r_rsp_mat   <= i_eng_mat_axb;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ack    = r_ack;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_mat    = r_rsp_mat;
    assign o_rsp_err    = r_rsp_err;
    assign o_eng_reset  = r_eng_reset;
    assign o_eng_enable = r_eng_enable;
    assign o_eng_mat_a  = r_eng_mat_a;
    assign o_eng_mat_b  = r_eng_mat_b;

endmodule

// File: tb/tb_mmul_arbiter.sv
// Directed bench for mmul_arbiter with a behavioural mmul engine and a response scoreboard.
module tb_mmul_arbiter;

    localparam int NREQ = 4, M = 2, N = 2, L = 2, W = 8;
    localparam int IW = 2, AW = M*N*W, BW = N*L*W, RW = M*L*W, MNL = M*N*L;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_a;
    logic [NREQ*BW-1:0]   req_b;
    logic [NREQ-1:0]      req_ack;
    logic                 rsp_valid, rsp_ready, rsp_err;
    logic [IW-1:0]        rsp_id;
    logic [RW-1:0]        rsp_mat;
    logic                 eng_reset, eng_enable, eng_done, eng_invalid;
    logic [AW-1:0]        eng_a;
    logic [BW-1:0]        eng_b;
    logic [RW-1:0]        eng_axb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int             id;
        logic [RW-1:0]  mat;
        logic           err;
    } exp_t;
    exp_t sb[$];

    // Engine model state
    int   e_cnt;
    logic e_done, e_copied;
    logic inv_mode, tie_done0;

    always #5 clk = ~clk;

    mmul_arbiter dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_mat_a(req_a), .i_req_mat_b(req_b),
        .o_req_ack(req_ack), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id), .o_rsp_mat(rsp_mat), .o_rsp_err(rsp_err),
        .o_eng_reset(eng_reset), .o_eng_enable(eng_enable), .o_eng_mat_a(eng_a),
        .o_eng_mat_b(eng_b), .i_eng_mat_axb(eng_axb), .i_eng_done(eng_done),
        .i_eng_invalid(eng_invalid)
    );

    // Reference matrix product with W-bit wrap.
    function automatic logic [RW-1:0] mmul_ref(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [RW-1:0] r;
        logic [W-1:0]  acc;
        r = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < L; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++)
                    acc = W'(acc + a[(i*N+k)*W +: W] * b[(k*L+j)*W +: W]);
                r[(i*L+j)*W +: W] = acc;
            end
        return r;
    endfunction

    // Engine: MNL enabled cycles to done, result copied the cycle after done.
    always @(posedge clk) begin
        if (eng_reset) begin
            e_cnt    <= 0;
            e_done   <= 1'b0;
            e_copied <= 1'b0;
            eng_axb  <= '0;
        end else begin
            if (eng_enable && !e_done) begin
                e_cnt <= e_cnt + 1;
                if (e_cnt == MNL - 1 && !tie_done0) e_done <= 1'b1;
            end
            if (e_done && !e_copied) begin
                eng_axb  <= mmul_ref(eng_a, eng_b);
                e_copied <= 1'b1;
            end
        end
    end
    assign eng_done    = e_done;
    assign eng_invalid = inv_mode && eng_enable && (e_cnt == 3);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for a grant, check it, and push the expected response.
    task automatic wait_ack(input logic [NREQ-1:0] exp_g, input bit drop, input bit exp_err);
        int   n = 0;
        int   g = 0;
        exp_t e;
        while (req_ack == '0 && n < 100) begin tick(); n++; end
        chk("ack_grant", 64'(req_ack), 64'(exp_g));
        chk("eng_reset_in_load", 64'(eng_reset), 64'd1);
        for (int i = 0; i < NREQ; i++) if (exp_g[i]) g = i;
        e.id  = g;
        e.err = exp_err;
        e.mat = exp_err ? '0 : mmul_ref(req_a[g*AW +: AW], req_b[g*BW +: BW]);
        sb.push_back(e);
        if (drop) req[g] = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 200) begin tick(); lat++; end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    endtask

    task automatic finish_rsp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_mat", 64'(rsp_mat), 64'(e.mat));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("valid_cleared", 64'(rsp_valid), 64'd0);
        chk("no_ack_at_handshake", 64'(req_ack), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        int bad;
        logic [RW-1:0] held;
        reset = 1'b1; req = '0; rsp_ready = 1'b0; inv_mode = 1'b0; tie_done0 = 1'b0;
        req_a = '0; req_b = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_mat", 64'(rsp_mat), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_eng_reset", 64'(eng_reset), 64'd1);
        chk("rst_eng_enable", 64'(eng_enable), 64'd0);
        chk("rst_eng_a", 64'(eng_a), 64'd0);
        chk("rst_eng_b", 64'(eng_b), 64'd0);
        reset = 1'b0;
        tick();

        // 1: single job, fixed operands and latency
        req_a[0 +: AW] = 32'h04030201;
        req_b[0 +: BW] = 32'h08070605;
        req = 4'b0001;
        wait_ack(4'b0001, 1'b1, 1'b0);
        chk("eng_a_latched", 64'(eng_a), 64'h04030201);
        wait_rsp(lat);
        chk("latency", 64'(lat), 64'(MNL + 3));
        chk("t1_mat_const", 64'(rsp_mat), 64'h322b1613);
        finish_rsp();

        // 2: all requesting, round-robin order from pointer 0
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            req_a[r*AW +: AW] = $urandom;
            req_b[r*BW +: BW] = $urandom;
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(4'(1 << (i % NREQ)), 1'b0, 1'b0);
            wait_rsp(lat);
            chk("rr_latency", 64'(lat), 64'(MNL + 3));
            finish_rsp();
        end
        req = '0;

        // 3: back-pressure; pointer is 1, so 2 wins over 3
        req = 4'b1100;
        wait_ack(4'b0100, 1'b1, 1'b0);
        wait_rsp(lat);
        held = rsp_mat;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_mat !== held || req_ack !== '0 || rsp_id !== 2'd2) bad++;
        end
        chk("stall_stable", 64'(bad), 64'd0);
        finish_rsp();
        wait_ack(4'b1000, 1'b1, 1'b0);
        wait_rsp(lat);
        finish_rsp();

        // 4: engine invalid, then a clean job that wraps the pointer
        inv_mode = 1'b1;
        req = 4'b0010;
        wait_ack(4'b0010, 1'b1, 1'b1);
        wait_rsp(lat);
        finish_rsp();
        inv_mode = 1'b0;
        req = 4'b0001;
        wait_ack(4'b0001, 1'b1, 1'b0);
        wait_rsp(lat);
        finish_rsp();

        // 5: reset mid-RUN drops the job and restores pointer 0
        req = 4'b0100;
        wait_ack(4'b0100, 1'b1, 1'b0);
        repeat (4) tick();
        chk("mid_run_enable", 64'(eng_enable), 64'd1);
        reset = 1'b1;
        tick();
        chk("abort_valid", 64'(rsp_valid), 64'd0);
        chk("abort_enable", 64'(eng_enable), 64'd0);
        chk("abort_eng_reset", 64'(eng_reset), 64'd1);
        chk("abort_mat", 64'(rsp_mat), 64'd0);
        chk("abort_id", 64'(rsp_id), 64'd0);
        chk("abort_eng_a", 64'(eng_a), 64'd0);
        sb.delete();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp_valid !== 1'b0) bad++;
        end
        chk("no_rsp_after_abort", 64'(bad), 64'd0);
        req = 4'b1111;
        wait_ack(4'b0001, 1'b1, 1'b0);
        req = '0;
        wait_rsp(lat);
        finish_rsp();

`ifdef MMUL_ARB_TIMEOUT_EN
        // 6: engine never finishes; watchdog reports an error
        tie_done0 = 1'b1;
        req = 4'b0010;
        wait_ack(4'b0010, 1'b1, 1'b1);
        wait_rsp(lat);
        chk("timeout_latency", 64'(lat), 64'(MNL + 8 + 1));
        chk("timeout_eng_reset", 64'(eng_reset), 64'd1);
        finish_rsp();
        tie_done0 = 1'b0;
`endif

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
